// File: rtl/multicycle_control_fsm_pkg.sv
// Shared constants for the multi-cycle RV32I controller: ALU operation codes,
// RV32I major opcodes, FSM state encodings and the control-word bundle.
package multicycle_control_fsm_pkg;

   localparam logic [4:0] ALU_ADD = 5'd0;
   localparam logic [4:0] ALU_SUB = 5'd1;
   localparam logic [4:0] ALU_SLL = 5'd2;
   localparam logic [4:0] ALU_XOR = 5'd3;
   localparam logic [4:0] ALU_SRL = 5'd4;
   localparam logic [4:0] ALU_OR  = 5'd5;
   localparam logic [4:0] ALU_AND = 5'd6;
   localparam logic [4:0] ALU_BEQ = 5'd7;
   localparam logic [4:0] ALU_BNE = 5'd8;
   localparam logic [4:0] ALU_BLT = 5'd9;
   localparam logic [4:0] ALU_BGE = 5'd10;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   localparam logic [2:0] S_IF    = 3'd0;
   localparam logic [2:0] S_ID    = 3'd1;
   localparam logic [2:0] S_EX    = 3'd2;
   localparam logic [2:0] S_MEM   = 3'd3;
   localparam logic [2:0] S_WB    = 3'd4;
   localparam logic [2:0] S_JALR2 = 3'd5;
   localparam logic [2:0] S_HALT  = 3'd6;

   typedef struct packed {
      logic [4:0] alu_op;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic       alu_out_write;
      logic       ir_write;
      logic       mem_read;
      logic       mem_write;
      logic       i_or_d;
      logic       reg_write;
      logic       pc_write;
      logic       pc_source;
      logic [1:0] wb_sel;
      logic       halted;
   } ctrl_t;

   function automatic ctrl_t ctrl_idle();
      ctrl_t c;
      c        = '0;
      c.alu_op = ALU_ADD;
      return c;
   endfunction

   // PC <= PC + 4 through the live ALU result; other fields are left untouched.
   function automatic ctrl_t pc_plus4(input ctrl_t c_in);
      ctrl_t c;
      c           = c_in;
      c.alu_src_a = 1'b0;
      c.alu_src_b = 2'd1;
      c.alu_op    = ALU_ADD;
      c.pc_write  = 1'b1;
      c.pc_source = 1'b0;
      return c;
   endfunction

endpackage

// File: rtl/multicycle_control_fsm_alu_control.sv
// ALU-control decode from opcode/funct3/funct7_5; shared with the pipelined core.
module alu_control
   import multicycle_control_fsm_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7_5,
   output logic [4:0] alu_op
);

   always_comb begin
      // NOTE: default first so every path assigns alu_op and no latch is inferred.
      alu_op = ALU_ADD;
      if (opcode == OP_R || opcode == OP_I) begin
         case (funct3)
            3'b000:  alu_op = (opcode == OP_R && funct7_5) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_op = ALU_SLL;
            3'b100:  alu_op = ALU_XOR;
            3'b101:  alu_op = ALU_SRL;
            3'b110:  alu_op = ALU_OR;
            3'b111:  alu_op = ALU_AND;
            default: alu_op = ALU_ADD;
         endcase
      end else if (opcode == OP_BRANCH) begin
         case (funct3)
            3'b001:         alu_op = ALU_BNE;
            3'b100, 3'b110: alu_op = ALU_BLT;
            3'b101, 3'b111: alu_op = ALU_BGE;
            default:        alu_op = ALU_BEQ;
         endcase
      end
   end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I sequencing FSM: state register plus combinational control
// word driving the shared ALU, PC, IR, ALUOut, register file and memory.
module multicycle_control_fsm
   import multicycle_control_fsm_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7_5,
   input  logic       alu_bcond,
   input  logic       mem_ready,
   output logic [4:0] alu_op,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic       alu_out_write,
   output logic       ir_write,
   output logic       mem_read,
   output logic       mem_write,
   output logic       i_or_d,
   output logic       reg_write,
   output logic       pc_write,
   output logic       pc_source,
   output logic [1:0] wb_sel,
   output logic       halted
);

   logic [2:0] state_q, state_d;
   logic [4:0] dec_alu_op;
   ctrl_t      ctrl;

   alu_control u_alu_control (
      .opcode   (opcode),
      .funct3   (funct3),
      .funct7_5 (funct7_5),
      .alu_op   (dec_alu_op)
   );

   logic is_r, is_i, is_load, is_store, is_branch, is_jal, is_jalr, is_ecall, is_known;
   assign is_r      = (opcode == OP_R);
   assign is_i      = (opcode == OP_I);
   assign is_load   = (opcode == OP_LOAD);
   assign is_store  = (opcode == OP_STORE);
   assign is_branch = (opcode == OP_BRANCH);
   assign is_jal    = (opcode == OP_JAL);
   assign is_jalr   = (opcode == OP_JALR);
   assign is_ecall  = (opcode == OP_SYSTEM) && (funct3 == 3'b000);
   assign is_known  = is_r | is_i | is_load | is_store | is_branch | is_jal | is_jalr;

   always_comb begin
      ctrl    = ctrl_idle();
      state_d = state_q;
      // Reset holds every enable low; the register itself returns to IF.
      if (reset) begin
         state_d = S_IF;
      end else begin
         case (state_q)
            S_IF: begin
               ctrl.mem_read = 1'b1;
               ctrl.ir_write = mem_ready;
               if (mem_ready) state_d = S_ID;
            end
            S_ID: begin
               if (!is_known && !is_ecall) begin
                  ctrl    = pc_plus4(ctrl);
                  state_d = S_IF;
               end else begin
                  ctrl.alu_src_b     = 2'd2;
                  ctrl.alu_out_write = 1'b1;
                  state_d            = is_ecall ? S_HALT : S_EX;
               end
            end
            S_EX: begin
               state_d = S_IF;
               if (is_r || is_i) begin
                  ctrl.alu_src_a     = 1'b1;
                  ctrl.alu_src_b     = is_r ? 2'd0 : 2'd2;
                  ctrl.alu_op        = dec_alu_op;
                  ctrl.alu_out_write = 1'b1;
                  state_d            = S_WB;
               end else if (is_load || is_store) begin
                  ctrl.alu_src_a     = 1'b1;
                  ctrl.alu_src_b     = 2'd2;
                  ctrl.alu_out_write = 1'b1;
                  state_d            = S_MEM;
               end else if (is_branch) begin
                  ctrl.alu_src_a = 1'b1;
                  ctrl.alu_src_b = 2'd0;
                  ctrl.alu_op    = dec_alu_op;
                  if (alu_bcond) begin
                     ctrl.pc_write  = 1'b1;
                     ctrl.pc_source = 1'b1;
                  end else begin
                     state_d = S_WB;
                  end
               end else if (is_jal) begin
                  // Link value is the live PC+4; the jump target comes from ALUOut.
                  ctrl           = pc_plus4(ctrl);
                  ctrl.reg_write = 1'b1;
                  ctrl.wb_sel    = 2'd2;
                  ctrl.pc_source = 1'b1;
               end else if (is_jalr) begin
                  ctrl.alu_src_a     = 1'b1;
                  ctrl.alu_src_b     = 2'd2;
                  ctrl.alu_out_write = 1'b1;
                  state_d            = S_JALR2;
               end
            end
            S_MEM: begin
               ctrl.i_or_d    = 1'b1;
               ctrl.mem_read  = is_load;
               ctrl.mem_write = is_store;
               if (mem_ready) begin
                  if (is_load) begin
                     state_d = S_WB;
                  end else begin
                     ctrl    = pc_plus4(ctrl);
                     state_d = S_IF;
                  end
               end
            end
            S_WB: begin
               ctrl = pc_plus4(ctrl);
               if (!is_branch) begin
                  ctrl.reg_write = 1'b1;
                  ctrl.wb_sel    = is_load ? 2'd1 : 2'd0;
               end
               state_d = S_IF;
            end
            S_JALR2: begin
               ctrl           = pc_plus4(ctrl);
               ctrl.reg_write = 1'b1;
               ctrl.wb_sel    = 2'd2;
               ctrl.pc_source = 1'b1;
               state_d        = S_IF;
            end
            S_HALT: ctrl.halted = 1'b1;
            default: state_d = S_IF;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignment only.
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IF;
      else       state_q <= state_d;
   end

   assign alu_op        = ctrl.alu_op;
   assign alu_src_a     = ctrl.alu_src_a;
   assign alu_src_b     = ctrl.alu_src_b;
   assign alu_out_write = ctrl.alu_out_write;
   assign ir_write      = ctrl.ir_write;
   assign mem_read      = ctrl.mem_read;
   assign mem_write     = ctrl.mem_write;
   assign i_or_d        = ctrl.i_or_d;
   assign reg_write     = ctrl.reg_write;
   assign pc_write      = ctrl.pc_write;
   assign pc_source     = ctrl.pc_source;
   assign wb_sel        = ctrl.wb_sel;
   assign halted        = ctrl.halted;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench: stimulus pushes hand-built expected control words per cycle,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_multicycle_control_fsm;
   import multicycle_control_fsm_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [6:0] opcode = '0;
   logic [2:0] funct3 = '0;
   logic       funct7_5 = 1'b0;
   logic       alu_bcond = 1'b0;
   logic       mem_ready = 1'b0;
   logic [4:0] alu_op;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic       alu_out_write, ir_write, mem_read, mem_write, i_or_d;
   logic       reg_write, pc_write, pc_source, halted;
   logic [1:0] wb_sel;

   multicycle_control_fsm dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
      .alu_bcond(alu_bcond), .mem_ready(mem_ready), .alu_op(alu_op),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_out_write(alu_out_write),
      .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
      .reg_write(reg_write), .pc_write(pc_write), .pc_source(pc_source),
      .wb_sel(wb_sel), .halted(halted)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0] op;
      logic       sa;
      logic [1:0] sb;
      logic       aow, irw, mr, mw, iod, rw, pw, ps;
      logic [1:0] wb;
      logic       h;
   } vec_t;

   typedef struct {
      vec_t  v;
      string tag;
   } exp_t;

   exp_t sb_q[$];
   int   total = 0;
   int   bad = 0;

   localparam logic [31:0] I_ADD  = 32'h002081B3;
   localparam logic [31:0] I_SUB  = 32'h402081B3;
   localparam logic [31:0] I_XORI = 32'h0050C193;
   localparam logic [31:0] I_SRA  = 32'h4020D1B3;
   localparam logic [31:0] I_LW   = 32'h0000A183;
   localparam logic [31:0] I_SW   = 32'h0020A023;
   localparam logic [31:0] I_BEQ  = 32'h00208063;
   localparam logic [31:0] I_BLT  = 32'h0020C063;
   localparam logic [31:0] I_JAL  = 32'h008000EF;
   localparam logic [31:0] I_JALR = 32'h000100E7;
   localparam logic [31:0] I_LUI  = 32'h000001B7;
   localparam logic [31:0] I_ECALL = 32'h00000073;

   function automatic vec_t v_idle();
      vec_t v;
      v    = '0;
      v.op = ALU_ADD;
      return v;
   endfunction

   function automatic vec_t v_if(input logic rdy);
      vec_t v;
      v     = v_idle();
      v.mr  = 1'b1;
      v.irw = rdy;
      return v;
   endfunction

   function automatic vec_t v_id();
      vec_t v;
      v     = v_idle();
      v.sb  = 2'd2;
      v.aow = 1'b1;
      return v;
   endfunction

   function automatic vec_t v_pc4(input vec_t v_in);
      vec_t v;
      v    = v_in;
      v.sa = 1'b0;
      v.sb = 2'd1;
      v.op = ALU_ADD;
      v.pw = 1'b1;
      v.ps = 1'b0;
      return v;
   endfunction

   function automatic vec_t v_ex(input logic [4:0] op, input logic [1:0] sb);
      vec_t v;
      v     = v_idle();
      v.op  = op;
      v.sa  = 1'b1;
      v.sb  = sb;
      v.aow = 1'b1;
      return v;
   endfunction

   function automatic vec_t v_wb(input logic [1:0] wb);
      vec_t v;
      v    = v_pc4(v_idle());
      v.rw = 1'b1;
      v.wb = wb;
      return v;
   endfunction

   function automatic vec_t v_mem(input logic ld, input logic st);
      vec_t v;
      v     = v_idle();
      v.iod = 1'b1;
      v.mr  = ld;
      v.mw  = st;
      return v;
   endfunction

   function automatic vec_t v_branch(input logic [4:0] op, input logic taken);
      vec_t v;
      v    = v_idle();
      v.op = op;
      v.sa = 1'b1;
      v.sb = 2'd0;
      v.pw = taken;
      v.ps = taken;
      return v;
   endfunction

   function automatic vec_t v_link();
      vec_t v;
      v    = v_pc4(v_idle());
      v.rw = 1'b1;
      v.wb = 2'd2;
      v.ps = 1'b1;
      return v;
   endfunction

   function automatic vec_t v_halt();
      vec_t v;
      v   = v_idle();
      v.h = 1'b1;
      return v;
   endfunction

   task automatic check(input string tag, input vec_t act, input vec_t exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %p want %p", tag, act, exp);
      end
   endtask

   // Drive one cycle of inputs and queue the control word expected this cycle.
   task automatic step(input logic [31:0] ins, input logic rst, input logic rdy,
                       input logic bc, input vec_t e, input string tag);
      exp_t x;
      opcode    = ins[6:0];
      funct3    = ins[14:12];
      funct7_5  = ins[30];
      reset     = rst;
      mem_ready = rdy;
      alu_bcond = bc;
      x.v       = e;
      x.tag     = tag;
      sb_q.push_back(x);
      @(posedge clk);
      #1;
   endtask

   initial begin
      forever begin
         exp_t e;
         vec_t a;
         @(negedge clk);
         if (sb_q.size() != 0) begin
            e     = sb_q.pop_front();
            a.op  = alu_op;     a.sa  = alu_src_a;     a.sb = alu_src_b;
            a.aow = alu_out_write; a.irw = ir_write;   a.mr = mem_read;
            a.mw  = mem_write;  a.iod = i_or_d;        a.rw = reg_write;
            a.pw  = pc_write;   a.ps  = pc_source;     a.wb = wb_sel;
            a.h   = halted;
            check(e.tag, a, e.v);
         end
      end
   end

   initial begin
      @(posedge clk);
      #1;
      step(I_SW, 1, 1, 1, v_idle(), "reset_state");

      step(I_ADD, 0, 1, 0, v_if(1), "add_if");
      step(I_ADD, 0, 1, 0, v_id(), "add_id");
      step(I_ADD, 0, 1, 0, v_ex(ALU_ADD, 2'd0), "add_ex");
      step(I_ADD, 0, 1, 0, v_wb(2'd0), "add_wb");

      step(I_SUB, 0, 0, 0, v_if(0), "sub_if_stall");
      step(I_SUB, 0, 1, 0, v_if(1), "sub_if");
      step(I_SUB, 0, 1, 0, v_id(), "sub_id");
      step(I_SUB, 0, 1, 0, v_ex(ALU_SUB, 2'd0), "sub_ex");
      step(I_SUB, 0, 1, 0, v_wb(2'd0), "sub_wb");

      step(I_XORI, 0, 1, 0, v_if(1), "xori_if");
      step(I_XORI, 0, 1, 0, v_id(), "xori_id");
      step(I_XORI, 0, 1, 0, v_ex(ALU_XOR, 2'd2), "xori_ex");
      step(I_XORI, 0, 1, 0, v_wb(2'd0), "xori_wb");

      step(I_SRA, 0, 1, 0, v_if(1), "sra_if");
      step(I_SRA, 0, 1, 0, v_id(), "sra_id");
      step(I_SRA, 0, 1, 0, v_ex(ALU_SRL, 2'd0), "sra_ex_srl");
      step(I_SRA, 0, 1, 0, v_wb(2'd0), "sra_wb");

      step(I_LW, 0, 1, 0, v_if(1), "lw_if");
      step(I_LW, 0, 1, 0, v_id(), "lw_id");
      step(I_LW, 0, 1, 0, v_ex(ALU_ADD, 2'd2), "lw_ex");
      step(I_LW, 0, 0, 0, v_mem(1, 0), "lw_mem_wait0");
      step(I_LW, 0, 0, 0, v_mem(1, 0), "lw_mem_wait1");
      step(I_LW, 0, 1, 0, v_mem(1, 0), "lw_mem_done");
      step(I_LW, 0, 1, 0, v_wb(2'd1), "lw_wb");

      step(I_BEQ, 0, 1, 0, v_if(1), "beq_t_if");
      step(I_BEQ, 0, 1, 0, v_id(), "beq_t_id");
      step(I_BEQ, 0, 1, 1, v_branch(ALU_BEQ, 1), "beq_t_ex");

      step(I_BEQ, 0, 1, 0, v_if(1), "beq_n_if");
      step(I_BEQ, 0, 1, 0, v_id(), "beq_n_id");
      step(I_BEQ, 0, 1, 0, v_branch(ALU_BEQ, 0), "beq_n_ex");
      step(I_BEQ, 0, 1, 0, v_pc4(v_idle()), "beq_n_wb");

      step(I_BLT, 0, 1, 0, v_if(1), "blt_if");
      step(I_BLT, 0, 1, 0, v_id(), "blt_id");
      step(I_BLT, 0, 1, 1, v_branch(ALU_BLT, 1), "blt_t_ex");

      step(I_JAL, 0, 1, 0, v_if(1), "jal_if");
      step(I_JAL, 0, 1, 0, v_id(), "jal_id");
      step(I_JAL, 0, 1, 0, v_link(), "jal_ex");

      step(I_JALR, 0, 1, 0, v_if(1), "jalr_if");
      step(I_JALR, 0, 1, 0, v_id(), "jalr_id");
      step(I_JALR, 0, 1, 0, v_ex(ALU_ADD, 2'd2), "jalr_ex");
      step(I_JALR, 0, 1, 0, v_link(), "jalr_jalr2");

      step(I_LUI, 0, 1, 0, v_if(1), "lui_if");
      step(I_LUI, 0, 1, 0, v_pc4(v_idle()), "lui_id_unknown");

      step(I_SW, 0, 1, 0, v_if(1), "sw_if");
      step(I_SW, 0, 1, 0, v_id(), "sw_id");
      step(I_SW, 0, 1, 0, v_ex(ALU_ADD, 2'd2), "sw_ex");
      step(I_SW, 0, 1, 0, v_pc4(v_mem(0, 1)), "sw_mem_done");

      step(I_SW, 0, 1, 0, v_if(1), "sw2_if");
      step(I_SW, 0, 1, 0, v_id(), "sw2_id");
      step(I_SW, 0, 1, 0, v_ex(ALU_ADD, 2'd2), "sw2_ex");
      step(I_SW, 0, 0, 0, v_mem(0, 1), "sw2_mem_wait");
      step(I_SW, 1, 0, 0, v_idle(), "sw2_mem_reset");

      step(I_ECALL, 0, 1, 0, v_if(1), "ecall_if_after_reset");
      step(I_ECALL, 0, 1, 0, v_id(), "ecall_id");
      step(I_ECALL, 0, 1, 0, v_halt(), "ecall_halt_c3");
      step(I_ECALL, 0, 0, 1, v_halt(), "ecall_halt_c4");
      step(I_ADD, 0, 1, 1, v_halt(), "ecall_halt_c5");
      step(I_ECALL, 1, 1, 0, v_idle(), "halt_reset");
      step(I_ECALL, 0, 0, 0, v_if(0), "halt_reset_if");

      for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(posedge clk);
      if (sb_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain: %0d expected words left, want 0", sb_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
